pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register with valid/ready handshake, flush, and an optional 2-entry skid buffer.
- Generalises the fixed EX→M latch, which has no stall or flush capability.
- Instantiated between any two core stages (ID/EX, EX/M, M/WB); upstream packs its payload into a data vector and a reset-critical control vector.
- Adds back-pressure, bubble insertion on flush, control gating, and a stall-cycle performance counter.

Parameters:
- DATA_W, 128: width of non-reset payload (PC, imm, operands, instr, ...).
- CTRL_W, 4: width of reset-critical control bits (rd_wen, MemWrite, ...); forced 0 whenever the corresponding valid is 0.
- SKID, 1:
  - 1 = two-entry skid buffer; in_ready is registered.
  - 0 = single register; in_ready is combinational from out_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous reset, active-low.
- in_valid, in, 1: upstream has a payload.
- in_ready, out, 1: stage can accept. Transfer occurs when in_valid && in_ready.
- in_data, in, DATA_W: upstream payload.
- in_ctrl, in, CTRL_W: upstream control bits.
- flush, in, 1: discard all held entries (branch/jalr redirect).
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream accepts. Transfer occurs when out_valid && out_ready.
- out_data, out, DATA_W: head payload.
- out_ctrl, out, CTRL_W: head control bits; all-zero when out_valid=0.
- stall_cnt, out, CNT_W: cycles with in_valid && !in_ready; saturating.
- stall_clr, in, 1: synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0 at posedge):
  - main_v=0, skid_v=0, ctrl registers=0, stall_cnt=0.
  - Hence out_valid=0, out_ctrl=0, in_ready=1.
  - Data registers are not reset; out_data is unspecified until the first accept, and benches must not compare it while out_valid=0.
- Latency: one cycle from an accepted input to out_valid. Throughput is 1/cycle while out_ready=1.
- Order: strict FIFO; entries are never reordered or duplicated.
- SKID=0:
  - in_ready = !main_v || out_ready.
  - On accept: main loads in_data/in_ctrl and main_v=1.
  - Otherwise, if out_ready: main_v=0.
- SKID=1, state {skid_v, main_v}, encoded as EMPTY(00), FULL(01), SKIDF(11):
  - in_ready = !skid_v (registered; no combinational path from out_ready).
  - EMPTY: on accept → FULL.
  - FULL:
    - accept && out_ready → FULL (main reloaded).
    - accept && !out_ready → SKIDF (input stored in skid).
    - !accept && out_ready → EMPTY.
    - Otherwise hold.
  - SKIDF: in_ready=0. On out_ready, skid moves to main → FULL. Otherwise hold.
  - State 10 is illegal; an assertion must flag it.
- Flush:
  - Takes priority over every other event.
  - At the posedge with flush=1: main_v=0, skid_v=0, ctrl registers=0.
  - Any input presented in the same cycle is dropped even if in_ready=1. Upstream must treat it as consumed, since the flush source also kills upstream.
  - The downstream transfer in the flush cycle still completes if out_valid && out_ready; it is the oldest instruction.
- out_ctrl = main_ctrl & {CTRL_W{main_v}}. Both ctrl registers are also cleared when their entry is vacated.
- stall_cnt:
  - Increments when in_valid && !in_ready && !flush.
  - Saturates at all-ones.
  - stall_clr has priority over increment.
  - Reset clears it.
- Reset mid-operation: all held entries are discarded and there is no partial output; behaviour is identical to flush plus a counter clear.
- Simultaneous stall_clr and increment: result is 0.

Decomposition:
- Shared package pipe_pkg:
  - State encoding typedef pipe_buf_state_e {EMPTY, FULL, SKIDF}.
  - Localparams for the standard EX/M payload layout (DATA_W and CTRL_W field offsets for PC, imm, rs2, rd, instr, PMAItoReg, rd_wen, MemWrite).
- One natural sub-module: pipe_entry_reg, a single entry holding data plus valid-gated ctrl with load/clear. Main and skid each instantiate one.
- The counter stays inline.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_ctrl=4'hF → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0. After release, the first accept appears one cycle later.
- Streaming: SKID=1, out_ready=1, send 8 payloads 0x10..0x17 back-to-back → out_data 0x10..0x17 on consecutive cycles, one cycle behind, with no stall.
- Back-pressure:
  - Setup: out_ready=0 for 3 cycles while in_valid=1 with payloads A, B, C.
  - Expected: FULL→SKIDF, in_ready=0 for 2 cycles, stall_cnt=2.
  - On out_ready=1: outputs A, B, C in order, none lost.
- Flush:
  - Setup: in SKIDF, assert flush with in_valid=1 payload D and out_ready=0.
  - Expected: next cycle out_valid=0, out_ctrl=0, in_ready=1; D is never output.
- Flush with concurrent drain: FULL with head X, flush=1, out_ready=1 → X is transferred in that cycle; stage is empty afterwards.
- Counter: CNT_W=4, force 20 stall cycles → stall_cnt saturates at 15. stall_clr coincident with a stall → 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage buffers.
//   pipe_buf_state_e : occupancy of a skid-buffered stage, encoded as {skid_v, main_v}.
//   EXM_*            : field layout of the standard EX/M payload (data and ctrl vectors).
//   state_legal()    : true unless the skid entry is occupied while main is empty.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKIDF = 2'b11
   } pipe_buf_state_e;

   // EX/M data vector: four 32-bit fields.
   localparam int unsigned EXM_DATA_W    = 128;
   localparam int unsigned EXM_PC_LSB    = 0;
   localparam int unsigned EXM_PC_W      = 32;
   localparam int unsigned EXM_IMM_LSB   = 32;
   localparam int unsigned EXM_IMM_W     = 32;
   localparam int unsigned EXM_RS2_LSB   = 64;
   localparam int unsigned EXM_RS2_W     = 32;
   localparam int unsigned EXM_INSTR_LSB = 96;
   localparam int unsigned EXM_INSTR_W   = 32;
   // rd is not stored separately; it is the instr[11:7] field.
   localparam int unsigned EXM_RD_LSB    = EXM_INSTR_LSB + 7;
   localparam int unsigned EXM_RD_W      = 5;

   // EX/M ctrl vector.
   localparam int unsigned EXM_CTRL_W        = 4;
   localparam int unsigned EXM_RD_WEN_BIT    = 0;
   localparam int unsigned EXM_MEMWRITE_BIT  = 1;
   localparam int unsigned EXM_PMAITOREG_LSB = 2;
   localparam int unsigned EXM_PMAITOREG_W   = 2;

   function automatic logic state_legal(input logic skid_v, input logic main_v);
      return !(skid_v && !main_v);
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer entry: payload data plus reset-critical ctrl bits and a valid flag.
//   clk, rst_n     : clock, synchronous active-low reset (clears valid and ctrl)
//   load           : capture in_data/in_ctrl and mark the entry valid
//   clear          : vacate the entry (valid and ctrl to zero); wins over load
//   in_data/in_ctrl: value to capture
//   valid          : entry occupied
//   data           : held payload (not reset; meaningless while valid=0)
//   ctrl           : held ctrl bits, forced to zero while valid=0
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         ctrl_q  <= in_ctrl;
      end
   end

   // Payload deliberately has no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= in_data;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign ctrl  = ctrl_q & {CTRL_W{valid_q}};

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, flush and optional 2-entry skid buffer.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready       : upstream handshake (in_ready registered when SKID=1)
//   in_data/in_ctrl         : upstream payload and reset-critical control bits
//   flush                   : discard every held entry and any same-cycle input
//   out_valid/out_ready     : downstream handshake
//   out_data/out_ctrl       : head entry (out_ctrl is zero while out_valid=0)
//   stall_cnt/stall_clr     : saturating count of upstream stall cycles, synchronous clear
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   logic              accept;
   logic              main_load;
   logic              main_clr;
   logic              main_src_skid;
   logic              main_v;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              skid_v;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [CNT_W-1:0]  stall_cnt_q;

   // A flushed input is dropped even when in_ready=1.
   assign accept = in_valid && in_ready && !flush;

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (main_load),
      .clear   (main_clr),
      .in_data (main_src_skid ? skid_data : in_data),
      .in_ctrl (main_src_skid ? skid_ctrl : in_ctrl),
      .valid   (main_v),
      .data    (main_data),
      .ctrl    (main_ctrl)
   );

   if (SKID != 0) begin : g_skid
      pipe_buf_state_e state;
      logic            skid_load;
      logic            skid_clr;

      assign state    = pipe_buf_state_e'({skid_v, main_v});
      // Registered ready: depends only on skid occupancy, never on out_ready.
      assign in_ready = !skid_v;

      always_comb begin
         main_load     = 1'b0;
         main_clr      = 1'b0;
         main_src_skid = 1'b0;
         skid_load     = 1'b0;
         skid_clr      = 1'b0;
         if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
         end else begin
            unique case (state)
               EMPTY: main_load = accept;
               FULL: begin
                  if (accept && out_ready) begin
                     main_load = 1'b1;
                  end else if (accept) begin
                     skid_load = 1'b1;
                  end else if (out_ready) begin
                     main_clr = 1'b1;
                  end
               end
               SKIDF: begin
                  if (out_ready) begin
                     main_load     = 1'b1;
                     main_src_skid = 1'b1;
                     skid_clr      = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      pipe_entry_reg #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_skid (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (skid_load),
         .clear   (skid_clr),
         .in_data (in_data),
         .in_ctrl (in_ctrl),
         .valid   (skid_v),
         .data    (skid_data),
         .ctrl    (skid_ctrl)
      );
   end else begin : g_flat
      assign skid_v    = 1'b0;
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign in_ready  = !main_v || out_ready;

      always_comb begin
         main_src_skid = 1'b0;
         main_load     = accept;
         main_clr      = flush || (!accept && out_ready);
      end
   end

   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};

   // Clear wins over increment; increment stops at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || stall_clr) begin
         stall_cnt_q <= '0;
      end else if (in_valid && !in_ready && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;

   a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                   state_legal(skid_v, main_v));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid-buffered and a single-register instance share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int NW = 4;
   typedef logic [CW+DW-1:0] ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          flush;
   logic          out_ready;
   logic          stall_clr;
   logic [1:0]    in_rdy;
   logic [1:0]    out_vld;
   logic [DW-1:0] out_dat [2];
   logic [CW-1:0] out_ctl [2];
   logic [NW-1:0] cnt     [2];

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t mq   [2][$];
   int   mcnt [2];

   always #5 clk = ~clk;

   // Index 0: single register, index 1: skid buffer.
   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_flat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_vld[0]),
      .out_ready(out_ready), .out_data(out_dat[0]), .out_ctrl(out_ctl[0]),
      .stall_cnt(cnt[0]), .stall_clr(stall_clr)
   );

   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_vld[1]),
      .out_ready(out_ready), .out_data(out_dat[1]), .out_ctrl(out_ctl[1]),
      .stall_cnt(cnt[1]), .stall_clr(stall_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: a FIFO of capacity 2 (skid) or 1 (flat, may refill while draining).
   function automatic bit m_ready(input int k);
      if (k == 1) return mq[1].size() < 2;
      return (mq[0].size() == 0) || out_ready;
   endfunction

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, input logic clr);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      stall_clr = clr;
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      bit   rdy [2];
      bit   acc [2];
      bit   deq [2];
      ent_t e;
      #1;
      for (int k = 0; k < 2; k++) begin
         rdy[k] = m_ready(k);
         check($sformatf("u%0d.out_valid", k), out_vld[k], mq[k].size() != 0);
         check($sformatf("u%0d.in_ready", k), in_rdy[k], rdy[k]);
         check($sformatf("u%0d.stall_cnt", k), cnt[k], mcnt[k]);
         if (mq[k].size() != 0) begin
            e = mq[k][0];
            check($sformatf("u%0d.out_data", k), out_dat[k], e[DW-1:0]);
            check($sformatf("u%0d.out_ctrl", k), out_ctl[k], e[DW+:CW]);
         end else begin
            check($sformatf("u%0d.out_ctrl", k), out_ctl[k], 0);
         end
         acc[k] = in_valid && rdy[k] && !flush;
         deq[k] = (mq[k].size() != 0) && out_ready;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            mq[k].delete();
            mcnt[k] = 0;
         end else begin
            if (deq[k]) void'(mq[k].pop_front());
            if (flush) mq[k].delete();
            else if (acc[k]) mq[k].push_back({in_ctrl, in_data});
            if (stall_clr) mcnt[k] = 0;
            else if (in_valid && !rdy[k] && !flush && mcnt[k] < 15) mcnt[k]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 32'hdead_beef, 4'hf, 1'b0, 1'b0, 1'b0);
      mcnt[0] = 0;
      mcnt[1] = 0;
      @(posedge clk);
      @(negedge clk);
      step();
      step();
      check("reset.out_valid", out_vld[1], 0);
      check("reset.out_ctrl", out_ctl[1], 0);
      check("reset.in_ready", in_rdy[1], 1);
      check("reset.stall_cnt", cnt[1], 0);

      // First accept after release appears one cycle later.
      rst_n = 1'b1;
      drive(1'b1, 32'h55, 4'h3, 1'b0, 1'b0, 1'b0);
      step();
      check("first.out_valid", out_vld[1], 1);
      check("first.out_data", out_dat[1], 32'h55);
      idle(2);

      // Streaming.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h10 + i, 4'(i), 1'b1, 1'b0, 1'b0);
         step();
      end
      idle(2);
      check("stream.no_stall", cnt[1], 0);

      // Back-pressure: A, B accepted, C stalls twice.
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'hA, 4'h1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hB, 4'h2, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hC, 4'h4, 1'b0, 1'b0, 1'b0);
         step();
      end
      check("bp.in_ready", in_rdy[1], 0);
      check("bp.stall_cnt", cnt[1], 2);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hC, 4'h4, 1'b1, 1'b0, 1'b0);
         step();
      end
      idle(4);

      // Flush while SKIDF; D must never come out.
      drive(1'b1, 32'h71, 4'h5, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h72, 4'h6, 1'b0, 1'b0, 1'b0);
      step();
      check("skidf.in_ready", in_rdy[1], 0);
      drive(1'b1, 32'hD, 4'hf, 1'b0, 1'b1, 1'b0);
      step();
      check("flush.out_valid", out_vld[1], 0);
      check("flush.out_ctrl", out_ctl[1], 0);
      check("flush.in_ready", in_rdy[1], 1);
      idle(3);

      // Flush with concurrent drain of head X.
      drive(1'b1, 32'h99, 4'h9, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      step();
      check("flushdrain.out_valid", out_vld[1], 0);
      idle(1);

      // Counter saturation, then clear coincident with a stall.
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 22; i++) begin
         drive(1'b1, 32'(i), 4'h8, 1'b0, 1'b0, 1'b0);
         step();
      end
      check("sat.stall_cnt", cnt[1], 15);
      drive(1'b1, 32'h1234, 4'h8, 1'b0, 1'b0, 1'b1);
      step();
      check("clr.stall_cnt", cnt[1], 0);

      // Reset mid-operation.
      rst_n = 1'b0;
      drive(1'b1, 32'h4321, 4'h7, 1'b0, 1'b0, 1'b0);
      step();
      check("midreset.out_valid", out_vld[1], 0);
      rst_n = 1'b1;
      idle(1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         drive(($urandom_range(0, 3) != 0), 32'($urandom), 4'($urandom),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 31) == 0));
         step();
      end
      rst_n = 1'b1;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
